// File: rtl/aes_ctr_xor_stage.sv
// aes_ctr_xor_stage: keystream FIFO, plaintext join and registered skid output.
// Define AES_CTR_XOR_STATS_EN to add the blk_count / stall_cycles counters.
module aes_ctr_xor_stage #(
    parameter int DATA_WIDTH    = 128,
    parameter int KS_FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_pt_tdata,
    input  logic                            s_pt_tvalid,
    input  logic                            s_pt_tlast,
    output logic                            s_pt_tready,
    input  logic [DATA_WIDTH-1:0]           s_ks_tdata,
    input  logic                            s_ks_tvalid,
    output logic                            s_ks_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            msg_done,
    output logic [$clog2(KS_FIFO_DEPTH):0]  ks_level
`ifdef AES_CTR_XOR_STATS_EN
    ,
    output logic [31:0]                     blk_count,
    output logic [31:0]                     stall_cycles
`endif
);

    localparam int AW = $clog2(KS_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(KS_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] ks_mem [KS_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  ks_wr;
    logic                  fire;
    logic                  drain;
    logic                  skid_valid;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [DATA_WIDTH-1:0] ct_data;

    // Ready depends on registered state only, never on m_axis_tready.
    assign s_ks_tready = (ks_level != FULL);
    assign s_pt_tready = (ks_level != '0) && !skid_valid;
    assign ks_wr       = s_ks_tvalid && s_ks_tready;
    assign fire        = s_pt_tvalid && s_pt_tready;
    assign drain       = m_axis_tvalid && m_axis_tready;
    assign ct_data     = s_pt_tdata ^ ks_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (ks_wr) begin
            ks_mem[wr_ptr] <= s_ks_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ks_level <= '0;
        end else begin
            if (ks_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({ks_wr, fire})
                2'b10:   ks_level <= ks_level + 1'b1;
                2'b01:   ks_level <= ks_level - 1'b1;
                default: ks_level <= ks_level;
            endcase
        end
    end

    // fire implies the skid slot is empty, so it never collides with a skid move.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
            skid_data     <= '0;
            msg_done      <= 1'b0;
        end else begin
            msg_done <= drain && m_axis_tlast;
            if (fire && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ct_data;
                m_axis_tlast  <= s_pt_tlast;
            end else if (fire) begin
                skid_valid <= 1'b1;
                skid_data  <= ct_data;
                skid_last  <= s_pt_tlast;
            end else if (drain) begin
                if (skid_valid) begin
                    m_axis_tdata <= skid_data;
                    m_axis_tlast <= skid_last;
                    skid_valid   <= 1'b0;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
        end
    end

`ifdef AES_CTR_XOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count    <= '0;
            stall_cycles <= '0;
        end else begin
            if (drain && (blk_count != '1)) begin
                blk_count <= blk_count + 32'd1;
            end
            if (s_pt_tvalid && !s_pt_tready && (ks_level == '0)
                && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_ctr_xor_stage.sv
// tb_aes_ctr_xor_stage: directed vector bench for aes_ctr_xor_stage.
// Stats checks are compiled in when AES_CTR_XOR_STATS_EN is defined.
module tb_aes_ctr_xor_stage;

    localparam int DW = 128;

    typedef struct {
        logic [DW-1:0] pt;
        logic [DW-1:0] ks;
        logic          last;
        logic [DW-1:0] ct;
    } vec_t;

    vec_t vec [8];

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_pt_tdata;
    logic          s_pt_tvalid;
    logic          s_pt_tlast;
    logic          s_pt_tready;
    logic [DW-1:0] s_ks_tdata;
    logic          s_ks_tvalid;
    logic          s_ks_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          msg_done;
    logic [2:0]    ks_level;
`ifdef AES_CTR_XOR_STATS_EN
    logic [31:0]   blk_count;
    logic [31:0]   stall_cycles;
`endif

    int total;
    int bad;

    aes_ctr_xor_stage dut (
        .clk           (clk),
        .rst           (rst),
        .s_pt_tdata    (s_pt_tdata),
        .s_pt_tvalid   (s_pt_tvalid),
        .s_pt_tlast    (s_pt_tlast),
        .s_pt_tready   (s_pt_tready),
        .s_ks_tdata    (s_ks_tdata),
        .s_ks_tvalid   (s_ks_tvalid),
        .s_ks_tready   (s_ks_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .msg_done      (msg_done),
        .ks_level      (ks_level)
`ifdef AES_CTR_XOR_STATS_EN
        ,
        .blk_count     (blk_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_pt_tdata    = '0;
        s_pt_tvalid   = 1'b0;
        s_pt_tlast    = 1'b0;
        s_ks_tdata    = '0;
        s_ks_tvalid   = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams the 8-entry table; optionally stalls the sink for 5 cycles
    // once word stall_oi sits in the output register.
    task automatic run_stream(input int stall_oi);
        int pi, ki, oi, cyc, stall, scyc, gaps, dones, maxlvl, extra, idx;
        logic [DW-1:0] held;
        logic started, did_stall;
        pi = 0; ki = 0; oi = 0; cyc = 0; stall = 0; scyc = 0;
        gaps = 0; dones = 0; maxlvl = 0; extra = 0;
        held = '0; started = 1'b0; did_stall = 1'b0;
        while (oi < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (msg_done) dones++;
            if (int'(ks_level) > maxlvl) maxlvl = int'(ks_level);
            if (stall_oi >= 0 && !did_stall && oi == stall_oi && m_axis_tvalid) begin
                did_stall = 1'b1;
                stall = 5;
                scyc = 0;
            end
            m_axis_tready = (stall == 0);
            if (stall > 0) begin
                if (scyc == 0) begin
                    held = m_axis_tdata;
                end else begin
                    chk("stall_hold", m_axis_tdata, held);
                    chk("stall_valid", DW'(m_axis_tvalid), DW'(1));
                    chk("stall_pt_rdy", DW'(s_pt_tready), DW'(0));
                end
                scyc++;
                stall--;
            end
            idx = (ki < 8) ? ki : 0;
            s_ks_tvalid = (ki < 8);
            s_ks_tdata  = vec[idx].ks;
            idx = (pi < 8) ? pi : 0;
            s_pt_tvalid = (pi < 8) && (ki >= 4 || pi > 0);
            s_pt_tdata  = vec[idx].pt;
            s_pt_tlast  = vec[idx].last;
            if (m_axis_tvalid) started = 1'b1;
            if (started && m_axis_tready && !m_axis_tvalid) gaps++;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("stream_data", m_axis_tdata, vec[oi].ct);
                chk("stream_last", DW'(m_axis_tlast), DW'(vec[oi].last));
                oi++;
            end
            if (s_ks_tvalid && s_ks_tready) ki++;
            if (s_pt_tvalid && s_pt_tready) pi++;
        end
        idle_inputs();
        m_axis_tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (msg_done) dones++;
            if (m_axis_tvalid) extra++;
        end
        chk("stream_count", DW'(oi), DW'(8));
        chk("stream_pt_used", DW'(pi), DW'(8));
        chk("stream_gaps", DW'(gaps), DW'(0));
        chk("stream_lvl_max_le4", DW'(maxlvl <= 4), DW'(1));
        chk("stream_msg_done", DW'(dones), DW'(1));
        chk("stream_no_dup", DW'(extra), DW'(0));
        if (stall_oi >= 0) chk("stall_seen", DW'(did_stall), DW'(1));
    endtask

    initial begin
        int acc;
        total = 0;
        bad   = 0;
        vec[0] = '{{4{32'h11111111}}, {4{32'h22222222}}, 1'b0, {4{32'h33333333}}};
        vec[1] = '{{4{32'h12345678}}, {4{32'hFFFFFFFF}}, 1'b0, {4{32'hEDCBA987}}};
        vec[2] = '{{4{32'hDEADBEEF}}, {4{32'h0F0F0F0F}}, 1'b0, {4{32'hD1A2B1E0}}};
        vec[3] = '{{4{32'h00000000}}, {4{32'hA5A5A5A5}}, 1'b0, {4{32'hA5A5A5A5}}};
        vec[4] = '{{4{32'hFFFFFFFF}}, {4{32'h5A5A5A5A}}, 1'b0, {4{32'hA5A5A5A5}}};
        vec[5] = '{{4{32'h80000001}}, {4{32'h80000001}}, 1'b0, {4{32'h00000000}}};
        vec[6] = '{{4{32'h0F0F0F0F}}, {4{32'h00FF00FF}}, 1'b0, {4{32'h0FF00FF0}}};
        vec[7] = '{{4{32'hCAFEF00D}}, {4{32'h13579BDF}}, 1'b1, {4{32'hD9A96BD2}}};

        // Reset state
        do_reset();
        chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
        chk("rst_tdata", m_axis_tdata, DW'(0));
        chk("rst_msg_done", DW'(msg_done), DW'(0));
        chk("rst_ks_level", DW'(ks_level), DW'(0));
        chk("rst_ks_rdy", DW'(s_ks_tready), DW'(1));
        chk("rst_pt_rdy", DW'(s_pt_tready), DW'(0));

        // Single-word message
        s_ks_tdata  = {16{8'h0F}};
        s_ks_tvalid = 1'b1;
        s_pt_tdata  = {8{16'hFF00}};
        s_pt_tlast  = 1'b1;
        s_pt_tvalid = 1'b1;
        chk("sw_pt_rdy_e1", DW'(s_pt_tready), DW'(0));
        @(negedge clk);
        s_ks_tvalid = 1'b0;
        chk("sw_level_e1", DW'(ks_level), DW'(1));
        chk("sw_pt_rdy_e2", DW'(s_pt_tready), DW'(1));
        chk("sw_valid_e2", DW'(m_axis_tvalid), DW'(0));
        @(negedge clk);
        s_pt_tvalid = 1'b0;
        s_pt_tlast  = 1'b0;
        chk("sw_valid_e3", DW'(m_axis_tvalid), DW'(1));
        chk("sw_data", m_axis_tdata, {8{16'hF00F}});
        chk("sw_last", DW'(m_axis_tlast), DW'(1));
        chk("sw_level_e2", DW'(ks_level), DW'(0));
        chk("sw_done_early", DW'(msg_done), DW'(0));
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("sw_done", DW'(msg_done), DW'(1));
        chk("sw_valid_after", DW'(m_axis_tvalid), DW'(0));
        @(negedge clk);
        chk("sw_done_pulse", DW'(msg_done), DW'(0));

        // Streaming, then streaming with a 5-cycle sink stall
        do_reset();
        run_stream(-1);
        do_reset();
        run_stream(3);

        // FIFO full
        do_reset();
        m_axis_tready = 1'b1;
        acc = 0;
        repeat (6) begin
            s_ks_tvalid = 1'b1;
            s_ks_tdata  = vec[acc].ks;
            @(negedge clk);
            if (s_ks_tready === 1'b0 && acc < 4) acc = acc;
            acc = int'(ks_level);
        end
        chk("full_level", DW'(ks_level), DW'(4));
        chk("full_ks_rdy", DW'(s_ks_tready), DW'(0));
        s_ks_tdata  = vec[4].ks;
        s_pt_tdata  = vec[0].pt;
        s_pt_tlast  = 1'b0;
        s_pt_tvalid = 1'b1;
        chk("full_ks_rdy_fire", DW'(s_ks_tready), DW'(0));
        @(negedge clk);
        s_pt_tvalid = 1'b0;
        chk("full_level_pop", DW'(ks_level), DW'(3));
        chk("full_ks_rdy_after", DW'(s_ks_tready), DW'(1));
        chk("full_out_valid", DW'(m_axis_tvalid), DW'(1));
        chk("full_out_data", m_axis_tdata, vec[0].ct);
        @(negedge clk);
        s_ks_tvalid = 1'b0;
        chk("full_level_refill", DW'(ks_level), DW'(4));

        // Reset mid-message: 2 ciphertext words held, 3 keystream words queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_ks_tvalid = 1'b1;
            s_ks_tdata  = vec[i].ks;
            @(negedge clk);
        end
        s_ks_tdata  = vec[4].ks;
        s_pt_tvalid = 1'b1;
        s_pt_tlast  = 1'b1;
        s_pt_tdata  = vec[0].pt;
        @(negedge clk);
        s_pt_tdata  = vec[1].pt;
        @(negedge clk);
        s_pt_tvalid = 1'b0;
        s_ks_tvalid = 1'b0;
        chk("mid_level", DW'(ks_level), DW'(3));
        chk("mid_valid", DW'(m_axis_tvalid), DW'(1));
        chk("mid_data", m_axis_tdata, vec[0].ct);
        chk("mid_pt_rdy", DW'(s_pt_tready), DW'(0));
        rst = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", DW'(m_axis_tvalid), DW'(0));
        chk("mid_rst_last", DW'(m_axis_tlast), DW'(0));
        chk("mid_rst_data", m_axis_tdata, DW'(0));
        chk("mid_rst_level", DW'(ks_level), DW'(0));
        chk("mid_rst_ks_rdy", DW'(s_ks_tready), DW'(1));
        chk("mid_rst_pt_rdy", DW'(s_pt_tready), DW'(0));
        chk("mid_rst_done", DW'(msg_done), DW'(0));
        @(negedge clk);
        chk("mid_rst_done2", DW'(msg_done), DW'(0));
        chk("mid_rst_valid2", DW'(m_axis_tvalid), DW'(0));

`ifdef AES_CTR_XOR_STATS_EN
        // Stats: 6 starved cycles, then 3 blocks
        do_reset();
        m_axis_tready = 1'b1;
        s_pt_tvalid = 1'b1;
        s_pt_tdata  = vec[0].pt;
        repeat (6) @(negedge clk);
        s_pt_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_ks_tvalid = 1'b1;
            s_ks_tdata  = vec[i].ks;
            @(negedge clk);
        end
        s_ks_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_pt_tvalid = 1'b1;
            s_pt_tdata  = vec[i].pt;
            s_pt_tlast  = (i == 2);
            @(negedge clk);
        end
        s_pt_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stat_stall", DW'(stall_cycles), DW'(6));
        chk("stat_blk", DW'(blk_count), DW'(3));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
